// File: rtl/mem_access_pkg.sv
// Shared encodings and the alignment rule for the load/store unit.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_RD,
    WAIT_RD,
    ISSUE_WR,
    RESP
  } state_e;

  // True for requests that must be rejected without touching the RAM.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane merge for sub-word stores and lane extract/extend for loads.
// Purely combinational, no latency; no flow control.
// Backpressure: none, outputs follow inputs in the same cycle.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = rd_word[{byte_off, 3'b000} +: 8];
    lane_h    = rd_word[{byte_off[1], 4'b0000} +: 16];
    merged    = rd_word;
    load_data = rd_word;
    case (size)
      SZ_BYTE: begin
        merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
        load_data = is_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        merged[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
        load_data = is_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      SZ_WORD: merged = wdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front end for a 32-bit synchronous RAM (RMW for sub-word stores).
// Latency from acceptance: error 1, word store 2, load 3, sub-word store 4 cycles.
// Backpressure: one request in flight; req_ready only in IDLE, response held until resp_ready.
module mem_access_unit #(
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddress,
  output logic [31:0]       memDataIn,
  input  logic [31:0]       memDataOut
);
  import mem_access_pkg::*;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         wr_word_q, wr_word_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                error_q, error_d;
  logic [31:0]         merged;
  logic [31:0]         load_data;

  // Lane logic always looks at the RAM output; it is only consumed in WAIT_RD.
  mem_lane_align u_align (
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .byte_off    (addr_q[1:0]),
    .rd_word     (memDataOut),
    .wdata       (wdata_q),
    .merged      (merged),
    .load_data   (load_data)
  );

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_word_d  = wr_word_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    req_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          if (is_bad_req(req_size, req_addr[1:0])) begin
            state_d = RESP;
            rdata_d = 32'b0;
            error_d = 1'b1;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_d   = ISSUE_WR;
            wr_word_d = req_wdata;
          end else begin
            state_d = ISSUE_RD;
          end
        end
      end
      ISSUE_RD: state_d = WAIT_RD;
      WAIT_RD: begin
        if (write_q) begin
          state_d   = ISSUE_WR;
          wr_word_d = merged;
        end else begin
          state_d = RESP;
          rdata_d = load_data;
          error_d = 1'b0;
        end
      end
      ISSUE_WR: begin
        state_d = RESP;
        rdata_d = 32'b0;
        error_d = 1'b0;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'b0;
      wr_word_q  <= 32'b0;
      rdata_q    <= 32'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_word_q  <= wr_word_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;
  assign memRead    = (state_q == ISSUE_RD);
  assign memWrite   = (state_q == ISSUE_WR);
  assign memAddress = addr_q[ADDR_W+1:2];
  assign memDataIn  = wr_word_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized checks of mem_access_unit against a byte-array memory model.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        memRead;
  logic        memWrite;
  logic [8:0]  memAddress;
  logic [31:0] memDataIn;
  logic [31:0] memDataOut;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  logic [31:0] last_rdata;
  logic [7:0]  ref_b [0:2047];

  mem_access_unit #(.ADDR_W(9)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .memAddress   (memAddress),
    .memDataIn    (memDataIn),
    .memDataOut   (memDataOut)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Attached 512 x 32 RAM with one-cycle read latency.
  logic [31:0] ram [0:511];
  initial begin
    for (int i = 0; i < 512; i++) ram[i] = init_word(i);
    memDataOut = 32'b0;
    forever begin
      @(posedge clock);
      if (memRead) memDataOut <= ram[memAddress];
      if (memWrite) ram[memAddress] <= memDataIn;
    end
  end

  always @(negedge clock) begin
    if (memRead) rd_cnt++;
    if (memWrite) wr_cnt++;
    if (memRead && memWrite) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input int a, input int sz, input bit uns);
    int nb;
    logic [31:0] v;
    nb = 1 << sz;
    v = 32'b0;
    for (int k = 0; k < nb; k++) v = v + (32'(ref_b[a + k]) << (8 * k));
    if (!uns && sz == 0 && v >= 32'd128) v = v | 32'hFFFFFF00;
    if (!uns && sz == 1 && v >= 32'd32768) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic xact(input bit wr, input logic [1:0] sz, input bit uns,
                      input logic [10:0] a, input logic [31:0] wd, input int hold);
    bit bad;
    logic [31:0] exp_d;
    int exp_lat, exp_rd, exp_wr, lat, rd0, wr0;
    bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    exp_d = 32'b0;
    if (bad) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (wr) begin
      exp_lat = (sz == 2'b10) ? 2 : 4;
      exp_rd  = (sz == 2'b10) ? 0 : 1;
      exp_wr  = 1;
      for (int k = 0; k < (1 << sz); k++) ref_b[int'(a) + k] = wd[8 * k +: 8];
    end else begin
      exp_lat = 3; exp_rd = 1; exp_wr = 0;
      exp_d = ref_load(int'(a), int'(sz), uns);
    end
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    resp_ready = (hold == 0);
    @(negedge clock);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clock);
    while (!resp_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rdata", resp_rdata, exp_d);
    check("error", 32'(resp_error), 32'(bad));
    last_rdata = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, exp_d);
      check("hold_ready", 32'(req_ready), 32'd0);
      @(negedge clock);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    check("mem_reads", 32'(rd_cnt - rd0), 32'(exp_rd));
    check("mem_writes", 32'(wr_cnt - wr0), 32'(exp_wr));
  endtask

  initial begin
    int wr0;
    for (int i = 0; i < 512; i++)
      for (int k = 0; k < 4; k++) ref_b[4 * i + k] = init_word(i) >> (8 * k);
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'b0; resp_ready = 1'b1;
    last_rdata = 32'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_error", 32'(resp_error), 32'd0);
    check("rst_mem_rw", 32'({memRead, memWrite}), 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    xact(1, 2'b10, 0, 11'h010, 32'hDEADBEEF, 0);
    xact(0, 2'b10, 0, 11'h010, 32'h0, 0);
    check("word_roundtrip", last_rdata, 32'hDEADBEEF);

    xact(1, 2'b10, 0, 11'h020, 32'h11223344, 0);
    xact(1, 2'b00, 0, 11'h022, 32'h000000AA, 0);
    xact(0, 2'b10, 0, 11'h020, 32'h0, 0);
    check("byte_merge", last_rdata, 32'h11AA3344);

    xact(1, 2'b10, 0, 11'h030, 32'h0000807F, 0);
    xact(0, 2'b00, 0, 11'h031, 32'h0, 0);
    check("byte_signed", last_rdata, 32'hFFFFFF80);
    xact(0, 2'b00, 1, 11'h031, 32'h0, 0);
    check("byte_unsigned", last_rdata, 32'h00000080);
    xact(0, 2'b01, 0, 11'h030, 32'h0, 0);
    check("half_signed", last_rdata, 32'hFFFF807F);

    xact(0, 2'b01, 0, 11'h003, 32'h0, 0);
    xact(0, 2'b10, 0, 11'h002, 32'h0, 0);
    xact(0, 2'b11, 0, 11'h000, 32'h0, 0);
    xact(1, 2'b11, 0, 11'h004, 32'h12345678, 0);

    xact(0, 2'b10, 0, 11'h020, 32'h0, 5);

    // Reset while the read half of a byte store is in flight.
    wr0 = wr_cnt;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 11'h041; req_wdata = 32'h000000C3;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_midflight_ready", 32'(req_ready), 32'd1);
    check("rst_midflight_valid", 32'(resp_valid), 32'd0);
    repeat (3) @(negedge clock);
    check("rst_no_write", 32'(wr_cnt - wr0), 32'd0);
    xact(0, 2'b10, 0, 11'h040, 32'h0, 0);
    check("rst_word_intact", last_rdata, init_word(16));

    for (int n = 0; n < 60; n++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
           11'($urandom_range(0, 127)), $urandom,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    check("never_rd_and_wr", 32'(both_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
